vga_rect_capture: RTL and testbench

- Receiving end of the pixel-clock VGA rectangle output: samples hsync, vsync and the 1-bit color stream, rebuilds pixel coordinates from the sync edges and measures the bounding box of lit pixels in each frame.
- Reports x0/x1/y0/y1 in the same signed-16 convention the generator consumes, plus measured line and frame totals for porch tuning.
- Sits on the same clock as the generator, in loopback self-test and in capture of external video.

---
 rtl/vga_rect_capture.sv | 200 ++++++++++++++++++++
 tb/tb_vga_rect_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_capture.sv
// Pixel-clock VGA receiver: rebuilds x/y from sync edges and measures
// the bounding box of lit pixels plus line/frame totals each frame.
module vga_rect_capture #(
    parameter logic HSYNC_ACT = 1'b0,
    parameter logic VSYNC_ACT = 1'b0,
    parameter int   H_BACK    = 24,
    parameter int   V_BACK    = 33
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               color,
    output logic signed [15:0] x0,
    output logic signed [15:0] x1,
    output logic signed [15:0] y0,
    output logic signed [15:0] y1,
    output logic               rect_found,
    output logic        [15:0] h_total,
    output logic        [15:0] v_total,
    output logic               frame_valid,
    output logic               locked
);

    typedef enum logic [1:0] {SEEK, CAPTURE, REPORT} state_t;

    localparam logic signed [15:0] SMAX   = 16'sh7fff;
    localparam logic signed [15:0] SMIN   = 16'sh8000;
    localparam logic signed [15:0] H_LOAD = 16'(-H_BACK);
    localparam logic signed [15:0] V_LOAD = 16'(-V_BACK);

    state_t r_state;
    state_t w_state_nx;

    logic r_hs_s1, r_hs_s2, r_hs_p;
    logic r_vs_s1, r_vs_s2, r_vs_p;
    logic r_col_s1, r_col_s2;

    logic signed [15:0] r_hcnt, r_vcnt;
    logic        [15:0] r_hlen, r_lines;
    logic        [15:0] w_lines_nx;

    logic signed [15:0] r_minx, r_maxx, r_miny, r_maxy;
    logic               r_seen;
    logic signed [15:0] w_minx_nx, w_maxx_nx, w_miny_nx, w_maxy_nx;
    logic signed [15:0] w_hcnt1, w_vcnt1;
    logic               w_seen_nx;

    logic w_hs_act, w_hs_pact, w_hs_rise, w_hs_fall;
    logic w_vs_act, w_vs_pact, w_vs_rise, w_vs_fall;
    logic w_qual, w_capture, w_go, w_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_s1  <= 1'b0;
            r_hs_s2  <= 1'b0;
            r_hs_p   <= 1'b0;
            r_vs_s1  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_vs_p   <= 1'b0;
            r_col_s1 <= 1'b0;
            r_col_s2 <= 1'b0;
        end else begin
            r_hs_s1  <= hsync;
            r_hs_s2  <= r_hs_s1;
            r_hs_p   <= r_hs_s2;
            r_vs_s1  <= vsync;
            r_vs_s2  <= r_vs_s1;
            r_vs_p   <= r_vs_s2;
            r_col_s1 <= color;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_hs_act  = (r_hs_s2 == HSYNC_ACT);
    assign w_hs_pact = (r_hs_p == HSYNC_ACT);
    assign w_hs_rise = w_hs_act & ~w_hs_pact;
    assign w_hs_fall = ~w_hs_act & w_hs_pact;
    assign w_vs_act  = (r_vs_s2 == VSYNC_ACT);
    assign w_vs_pact = (r_vs_p == VSYNC_ACT);
    assign w_vs_rise = w_vs_act & ~w_vs_pact;
    assign w_vs_fall = ~w_vs_act & w_vs_pact;

    // The hsync rise coinciding with vsync rise closes the ending frame.
    assign w_lines_nx = (w_hs_rise && r_lines != 16'hffff)
                      ? r_lines + 16'd1 : r_lines;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_hlen  <= '0;
            r_lines <= '0;
            h_total <= '0;
        end else begin
            if (w_hs_fall)
                r_hcnt <= H_LOAD;
            else if (r_hcnt != SMAX)
                r_hcnt <= r_hcnt + 16'sd1;
            if (w_vs_fall)
                r_vcnt <= V_LOAD;
            else if (w_hs_fall && r_vcnt != SMAX)
                r_vcnt <= r_vcnt + 16'sd1;
            if (w_hs_rise) begin
                h_total <= r_hlen;
                r_hlen  <= 16'd1;
            end else if (r_hlen != 16'hffff) begin
                r_hlen <= r_hlen + 16'd1;
            end
            r_lines <= w_vs_rise ? 16'd0 : w_lines_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= SEEK;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            SEEK:    if (w_vs_rise) w_state_nx = CAPTURE;
            CAPTURE: if (w_vs_rise) w_state_nx = REPORT;
            REPORT:  w_state_nx = CAPTURE;
            default: w_state_nx = SEEK;
        endcase
    end

    always_comb begin
        w_capture   = (r_state == CAPTURE);
        w_go        = w_capture & w_vs_rise;
        w_clr       = ((r_state == SEEK) & w_vs_rise) | (r_state == REPORT);
        frame_valid = (r_state == REPORT);
    end

    // A pixel on the vsync-rise cycle still belongs to the ending frame.
    always_comb begin
        w_qual = w_capture && !w_hs_act && (!w_vs_act || w_vs_rise)
              && !r_hcnt[15] && !r_vcnt[15] && r_col_s2;
        w_hcnt1   = (r_hcnt == SMAX) ? SMAX : r_hcnt + 16'sd1;
        w_vcnt1   = (r_vcnt == SMAX) ? SMAX : r_vcnt + 16'sd1;
        w_minx_nx = r_minx;
        w_maxx_nx = r_maxx;
        w_miny_nx = r_miny;
        w_maxy_nx = r_maxy;
        w_seen_nx = r_seen | w_qual;
        if (w_qual) begin
            if (r_hcnt < r_minx)  w_minx_nx = r_hcnt;
            if (w_hcnt1 > r_maxx) w_maxx_nx = w_hcnt1;
            if (r_vcnt < r_miny)  w_miny_nx = r_vcnt;
            if (w_vcnt1 > r_maxy) w_maxy_nx = w_vcnt1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_minx <= SMAX;
            r_maxx <= SMIN;
            r_miny <= SMAX;
            r_maxy <= SMIN;
            r_seen <= 1'b0;
        end else if (w_clr) begin
            r_minx <= SMAX;
            r_maxx <= SMIN;
            r_miny <= SMAX;
            r_maxy <= SMIN;
            r_seen <= 1'b0;
        end else begin
            r_minx <= w_minx_nx;
            r_maxx <= w_maxx_nx;
            r_miny <= w_miny_nx;
            r_maxy <= w_maxy_nx;
            r_seen <= w_seen_nx;
        end
    end

    // Loaded on entry to REPORT so they are valid alongside frame_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0         <= '0;
            x1         <= '0;
            y0         <= '0;
            y1         <= '0;
            rect_found <= 1'b0;
            v_total    <= '0;
            locked     <= 1'b0;
        end else if (w_go) begin
            x0         <= w_seen_nx ? w_minx_nx : '0;
            x1         <= w_seen_nx ? w_maxx_nx : '0;
            y0         <= w_seen_nx ? w_miny_nx : '0;
            y1         <= w_seen_nx ? w_maxy_nx : '0;
            rect_found <= w_seen_nx;
            v_total    <= w_lines_nx;
            locked     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_rect_capture.sv
// Randomized frame bench for vga_rect_capture with a pixel-level
// bounding-box reference model.
module tb_vga_rect_capture;

    localparam int HB = 8;
    localparam int VB = 4;
    localparam int HS = 4;
    localparam int VS = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               hsync, vsync, color;
    logic signed [15:0] x0, x1, y0, y1;
    logic               rect_found, frame_valid, locked;
    logic        [15:0] h_total, v_total;

    vga_rect_capture #(
        .HSYNC_ACT(1'b0),
        .VSYNC_ACT(1'b0),
        .H_BACK   (HB),
        .V_BACK   (VB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .color      (color),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .rect_found (rect_found),
        .h_total    (h_total),
        .v_total    (v_total),
        .frame_valid(frame_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int vs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
    end

    // Reference state: bbox of the frame being driven, and expected outputs.
    int cur_minx, cur_maxx, cur_miny, cur_maxy;
    bit cur_seen;
    bit armed = 1'b0;
    bit exp_rep;
    int mo_x0, mo_x1, mo_y0, mo_y1, mo_found, mo_locked, mo_vtot;
    int exp_fv = 0;
    int last_ht = 0;
    int last_vt = 0;
    int hexp;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_x0"}, x0, mo_x0);
        check({pfx, "_x1"}, x1, mo_x1);
        check({pfx, "_y0"}, y0, mo_y0);
        check({pfx, "_y1"}, y1, mo_y1);
        check({pfx, "_found"}, rect_found, mo_found);
        check({pfx, "_locked"}, locked, mo_locked);
        check({pfx, "_vtotal"}, v_total, mo_vtot);
    endtask

    task automatic drive_frame(input int ht, input int vt,
                               input int rx0, input int rx1,
                               input int ry0, input int ry1,
                               input bit lit, input int rst_line);
        int x, y;
        bit c;
        for (int l = 0; l < vt; l++) begin
            for (int j = 0; j < ht; j++) begin
                @(posedge clk);
                #1;
                if (l == 0 && j == 0) begin
                    exp_rep = armed;
                    if (armed) begin
                        exp_fv++;
                        mo_found  = cur_seen;
                        mo_x0     = cur_seen ? cur_minx : 0;
                        mo_x1     = cur_seen ? cur_maxx + 1 : 0;
                        mo_y0     = cur_seen ? cur_miny : 0;
                        mo_y1     = cur_seen ? cur_maxy + 1 : 0;
                        mo_vtot   = last_vt;
                        mo_locked = 1;
                    end
                    hexp     = last_ht;
                    armed    = 1'b1;
                    cur_seen = 1'b0;
                    cur_minx = 32767;
                    cur_miny = 32767;
                    cur_maxx = -1;
                    cur_maxy = -1;
                    vs_cyc   = cyc;
                end
                hsync = (j < HS) ? 1'b0 : 1'b1;
                vsync = (l < VS) ? 1'b0 : 1'b1;
                x = j - HS - HB - 1;
                y = l - VS - VB + 1;
                c = 1'b0;
                if (j > HS && l >= VS) begin
                    if (lit && x >= rx0 && x < rx1 && y >= ry0 && y < ry1)
                        c = 1'b1;
                    else if ((x < 0 || y < 0) && $urandom_range(0, 7) == 0)
                        c = 1'b1;
                end
                color = c;
                if (c && x >= 0 && y >= 0) begin
                    cur_seen = 1'b1;
                    if (x < cur_minx) cur_minx = x;
                    if (x > cur_maxx) cur_maxx = x;
                    if (y < cur_miny) cur_miny = y;
                    if (y > cur_maxy) cur_maxy = y;
                end
                if (l == rst_line && j == ht / 2) begin
                    reset_n = 1'b0;
                    armed = 1'b0;
                    mo_x0 = 0; mo_x1 = 0; mo_y0 = 0; mo_y1 = 0;
                    mo_found = 0; mo_locked = 0; mo_vtot = 0;
                    #1;
                    check_outputs("rst_mid");
                    check("rst_mid_fv", frame_valid, 0);
                end
                if (l == rst_line && j == ht / 2 + 3) reset_n = 1'b1;
                if (l == 0 && j == ht - 1) begin
                    check("fv_count", fv_cnt, exp_fv);
                    check_outputs("frame");
                    if (exp_rep) begin
                        check("fv_latency", fv_cyc - vs_cyc, 3);
                        check("h_total", h_total, hexp);
                    end
                end
            end
        end
        last_ht = ht;
        last_vt = vt;
    endtask

    task automatic random_frame(input int rst_line);
        int ht, vt, w, h, rx0, rx1, ry0, ry1;
        bit lit;
        ht  = int'($urandom_range(40, 70));
        vt  = int'($urandom_range(16, 30));
        w   = ht - HS - HB - 1;
        h   = vt - VS - VB + 1;
        rx0 = int'($urandom_range(0, w)) - 4;
        rx1 = rx0 + 1 + int'($urandom_range(0, w / 2));
        ry0 = int'($urandom_range(0, h)) - 2;
        ry1 = ry0 + 1 + int'($urandom_range(0, h / 2));
        lit = ($urandom_range(0, 5) != 0);
        drive_frame(ht, vt, rx0, rx1, ry0, ry1, lit, rst_line);
    endtask

    initial begin
        reset_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        color = 1'b0;
        mo_x0 = 0; mo_x1 = 0; mo_y0 = 0; mo_y1 = 0;
        mo_found = 0; mo_locked = 0; mo_vtot = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_fv", frame_valid, 0);
        check("reset_htotal", h_total, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        drive_frame(70, 110, 10, 50, 20, 100, 1'b1, -1);
        drive_frame(70, 110, 10, 50, 20, 100, 1'b1, -1);
        drive_frame(60, 24, 0, 0, 0, 0, 1'b0, -1);
        drive_frame(40, 16, 0, 1, 0, 1, 1'b1, -1);
        drive_frame(48, 20, -5, 20, 3, 9, 1'b1, -1);
        drive_frame(400, 12, 100, 300, 1, 5, 1'b1, -1);
        random_frame(-1);
        random_frame(5);
        for (int k = 0; k < 6; k++) random_frame(-1);
        drive_frame(50, 1, 0, 0, 0, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
